// File: rtl/sub11_pkg.sv
// Shared widths, segment offsets and pipeline stage payloads for the 11-bit
// carry-select-style subtractor.
package sub11_pkg;

    localparam int SUB_W    = 11;
    localparam int SEG0_W   = 3;
    localparam int SEG1_W   = 4;
    localparam int SEG2_W   = 4;
    localparam int SEG0_LSB = 0;
    localparam int SEG1_LSB = 3;
    localparam int SEG2_LSB = 7;
    localparam int STAGES   = 3;

    typedef struct packed {
        logic [SEG1_W-1:0] diff0;
        logic [SEG1_W-1:0] diff1;
        logic              bor0;
        logic              bor1;
    } seg1_cand_t;

    typedef struct packed {
        logic [SEG2_W-1:0] diff0;
        logic [SEG2_W-1:0] diff1;
        logic              bor0;
        logic              bor1;
    } seg2_cand_t;

    // Stage 1: S0 resolved, S1/S2 still as candidate pairs.
    typedef struct packed {
        logic [SEG0_W-1:0] d0;
        logic              br0;
        seg1_cand_t        s1;
        seg2_cand_t        s2;
        logic              a_msb;
        logic              b_msb;
    } st1_t;

    // Stage 2: S0+S1 resolved, S2 still a candidate pair.
    typedef struct packed {
        logic [SEG2_LSB-1:0] d_lo;
        logic                br1;
        seg2_cand_t          s2;
        logic                a_msb;
        logic                b_msb;
    } st2_t;

    typedef struct packed {
        logic [SUB_W-1:0] d;
        logic             bout;
        logic             ovf;
    } st3_t;

    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/sub11_pipe_if.sv
// Operand/result handshake bundle for sub11_pipe. master = producer/consumer
// side, slave = the subtractor.
interface sub11_pipe_if;
    import sub11_pkg::*;

    logic [SUB_W-1:0] a;
    logic [SUB_W-1:0] b;
    logic             bin;
    logic             in_valid;
    logic             in_ready;
    logic [SUB_W-1:0] d;
    logic             bout;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, bin, in_valid, out_ready,
        input  in_ready, d, bout, ovf, out_valid
    );

    modport slave (
        input  a, b, bin, in_valid, out_ready,
        output in_ready, d, bout, ovf, out_valid
    );

endinterface

// File: rtl/csel_sub_seg.sv
// Combinational segment subtractor producing both borrow-in candidates;
// the borrow is the MSB of a (W+1)-bit difference.
module csel_sub_seg #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff0,
    output logic         o_bor0,
    output logic [W-1:0] o_diff1,
    output logic         o_bor1
);

    logic [W:0] w_r0;
    logic [W:0] w_r1;

    assign w_r0 = {1'b0, i_a} - {1'b0, i_b};
    assign w_r1 = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, 1'b1};

    assign o_diff0 = w_r0[W-1:0];
    assign o_bor0  = w_r0[W];
    assign o_diff1 = w_r1[W-1:0];
    assign o_bor1  = w_r1[W];

endmodule

// File: rtl/sub11_pipe.sv
// 3-stage pipelined 11-bit subtractor with borrow-in/out and signed overflow;
// each carry-select boundary sits on a register, full valid/ready back-pressure.
module sub11_pipe
    import sub11_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    sub11_pipe_if.slave  bus
);

    logic [STAGES:1] r_vld;
    st1_t            r_s1;
    st2_t            r_s2;
    st3_t            r_s3;

    logic w_rdy1, w_rdy2, w_rdy3;
    logic w_adv1, w_adv2, w_adv3;

    // Ready chain: a stage may load when empty or when its successor moves.
    assign w_rdy3 = !r_vld[3] || bus.out_ready;
    assign w_rdy2 = !r_vld[2] || w_rdy3;
    assign w_rdy1 = !r_vld[1] || w_rdy2;

    assign w_adv1 = w_rdy1 && bus.in_valid;
    assign w_adv2 = w_rdy2 && r_vld[1];
    assign w_adv3 = w_rdy3 && r_vld[2];

    // Stage 1 datapath
    logic [SEG0_W:0]   w_s0;
    logic [SEG1_W-1:0] w_s1_d0, w_s1_d1;
    logic              w_s1_b0, w_s1_b1;
    logic [SEG2_W-1:0] w_s2_d0, w_s2_d1;
    logic              w_s2_b0, w_s2_b1;
    st1_t              w_st1;

    assign w_s0 = {1'b0, bus.a[SEG0_LSB +: SEG0_W]}
                - {1'b0, bus.b[SEG0_LSB +: SEG0_W]}
                - {{SEG0_W{1'b0}}, bus.bin};

    csel_sub_seg #(.W(SEG1_W)) u_seg1 (
        .i_a     (bus.a[SEG1_LSB +: SEG1_W]),
        .i_b     (bus.b[SEG1_LSB +: SEG1_W]),
        .o_diff0 (w_s1_d0),
        .o_bor0  (w_s1_b0),
        .o_diff1 (w_s1_d1),
        .o_bor1  (w_s1_b1)
    );

    csel_sub_seg #(.W(SEG2_W)) u_seg2 (
        .i_a     (bus.a[SEG2_LSB +: SEG2_W]),
        .i_b     (bus.b[SEG2_LSB +: SEG2_W]),
        .o_diff0 (w_s2_d0),
        .o_bor0  (w_s2_b0),
        .o_diff1 (w_s2_d1),
        .o_bor1  (w_s2_b1)
    );

    always_comb begin
        w_st1          = '0;
        w_st1.d0       = w_s0[SEG0_W-1:0];
        w_st1.br0      = w_s0[SEG0_W];
        w_st1.s1.diff0 = w_s1_d0;
        w_st1.s1.diff1 = w_s1_d1;
        w_st1.s1.bor0  = w_s1_b0;
        w_st1.s1.bor1  = w_s1_b1;
        w_st1.s2.diff0 = w_s2_d0;
        w_st1.s2.diff1 = w_s2_d1;
        w_st1.s2.bor0  = w_s2_b0;
        w_st1.s2.bor1  = w_s2_b1;
        w_st1.a_msb    = bus.a[SUB_W-1];
        w_st1.b_msb    = bus.b[SUB_W-1];
    end

    // Stage 2: br0 picks the S1 candidate
    st2_t w_st2;

    always_comb begin
        w_st2       = '0;
        w_st2.d_lo  = {(r_s1.br0 ? r_s1.s1.diff1 : r_s1.s1.diff0), r_s1.d0};
        w_st2.br1   = r_s1.br0 ? r_s1.s1.bor1 : r_s1.s1.bor0;
        w_st2.s2    = r_s1.s2;
        w_st2.a_msb = r_s1.a_msb;
        w_st2.b_msb = r_s1.b_msb;
    end

    // Stage 3: br1 picks the S2 candidate
    st3_t              w_st3;
    logic [SEG2_W-1:0] w_hi;

    always_comb begin
        w_hi       = r_s2.br1 ? r_s2.s2.diff1 : r_s2.s2.diff0;
        w_st3      = '0;
        w_st3.d    = {w_hi, r_s2.d_lo};
        w_st3.bout = r_s2.br1 ? r_s2.s2.bor1 : r_s2.s2.bor0;
        w_st3.ovf  = sub_ovf(r_s2.a_msb, r_s2.b_msb, w_hi[SEG2_W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_s1  <= '0;
            r_s2  <= '0;
            r_s3  <= '0;
        end else begin
            if (w_rdy1) r_vld[1] <= bus.in_valid;
            if (w_rdy2) r_vld[2] <= r_vld[1];
            if (w_rdy3) r_vld[3] <= r_vld[2];
            if (w_adv1) r_s1 <= w_st1;
            if (w_adv2) r_s2 <= w_st2;
            if (w_adv3) r_s3 <= w_st3;
        end
    end

    assign bus.in_ready  = w_rdy1;
    assign bus.out_valid = r_vld[3];
    assign bus.d         = r_s3.d;
    assign bus.bout      = r_s3.bout;
    assign bus.ovf       = r_s3.ovf;

endmodule
